// File: rtl/rr_grant_arbiter8_if.sv
// Request/grant bundle between eight requesters and the round-robin arbiter.
// The master side drives requests; the slave side (arbiter) drives the grant.
interface rr_grant_arbiter8_if #(
    parameter int N    = 8,
    parameter int IDXW = 3
);
    logic [N-1:0]    req;
    logic [N-1:0]    grant;
    logic [IDXW-1:0] grant_idx;
    logic            grant_valid;
    logic            preempt;

    modport master (
        output req,
        input  grant, grant_idx, grant_valid, preempt
    );

    modport slave (
        input  req,
        output grant, grant_idx, grant_valid, preempt
    );
endinterface

// File: rtl/rr_grant_arbiter8.sv
// Eight-way round-robin arbiter with registered one-hot grant, encoded index,
// hold-while-requested ownership and optional forced preemption after MAX_HOLD cycles.
module rr_grant_arbiter8 #(
    parameter int N        = 8,
    parameter int IDXW     = 3,
    parameter int MAX_HOLD = 4
) (
    input logic                clk,
    input logic                rst,
    rr_grant_arbiter8_if.slave bus
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    grant_q, grant_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [IDXW-1:0] ptr_q, ptr_d;
    logic [7:0]      hold_q, hold_d;
    logic            vld_q, vld_d;
    logic            preempt_q, preempt_d;

    logic            own_req;
    logic            expired;
    logic [IDXW-1:0] rot_ptr;
    logic [IDXW:0]   win_cur;
    logic [IDXW:0]   win_rot;

    // {found, index} of the first set request scanning upward from p, wrapping.
    function automatic logic [IDXW:0] pick(input logic [N-1:0] r, input logic [IDXW-1:0] p);
        logic [IDXW-1:0] pos;
        pick = '0;
        for (int i = N - 1; i >= 0; i--) begin
            pos = p + IDXW'(i);
            if (r[pos]) pick = {1'b1, pos};
        end
    endfunction

    assign own_req = bus.req[idx_q];
    assign expired = (MAX_HOLD != 0) && (int'(hold_q) >= MAX_HOLD);
    assign rot_ptr = idx_q + IDXW'(1);
    assign win_cur = pick(bus.req, ptr_q);
    assign win_rot = pick(bus.req, rot_ptr);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            idx_q     <= '0;
            ptr_q     <= '0;
            hold_q    <= '0;
            vld_q     <= 1'b0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            vld_q     <= vld_d;
            preempt_q <= preempt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (|bus.req) state_d = BUSY;
            BUSY: if (!own_req && !(|bus.req)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        grant_d   = grant_q;
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        preempt_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_cur[IDXW]) begin
                    grant_d                     = '0;
                    grant_d[win_cur[IDXW-1:0]] = 1'b1;
                    idx_d                       = win_cur[IDXW-1:0];
                    hold_d                      = 8'd1;
                end
            end
            BUSY: begin
                if (own_req && !expired) begin
                    hold_d = (hold_q == 8'hFF) ? hold_q : hold_q + 8'd1;
                end else begin
                    // Release or expiry: owner drops to lowest priority, hand over in the same edge.
                    ptr_d = rot_ptr;
                    if (win_rot[IDXW]) begin
                        grant_d                     = '0;
                        grant_d[win_rot[IDXW-1:0]] = 1'b1;
                        idx_d                       = win_rot[IDXW-1:0];
                        hold_d                      = 8'd1;
                        preempt_d                   = own_req && (win_rot[IDXW-1:0] != idx_q);
                    end else begin
                        grant_d = '0;
                        hold_d  = '0;
                    end
                end
            end
            default: begin
                grant_d = '0;
                hold_d  = '0;
            end
        endcase
        vld_d = |grant_d;
    end

    assign bus.grant       = grant_q;
    assign bus.grant_idx   = idx_q;
    assign bus.grant_valid = vld_q;
    assign bus.preempt     = preempt_q;

endmodule

// File: tb/tb_rr_grant_arbiter8.sv
// Bench for rr_grant_arbiter8: directed vector table, a reactive rotation sequence,
// and randomized requests compared against a cycle-level model of the arbitration rules.
module tb_rr_grant_arbiter8;

    localparam int MAXH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    rr_grant_arbiter8_if bus ();

    rr_grant_arbiter8 #(.N(8), .IDXW(3), .MAX_HOLD(MAXH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic [7:0] g;
        logic [2:0] idx;
        logic       v;
        logic       p;
    } vec_t;

    vec_t tbl[$];

    // Behavioural model state: owner is -1 when nothing is granted.
    int m_owner, m_idx, m_ptr, m_hold;
    bit m_pre;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic [7:0] q);
        rst     = r;
        bus.req = q;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic [7:0] q, input logic [7:0] g,
                       input logic [2:0] idx, input logic v, input logic p);
        vec_t e;
        e.rst = r; e.req = q; e.g = g; e.idx = idx; e.v = v; e.p = p;
        tbl.push_back(e);
    endtask

    function automatic int first_from(input logic [7:0] r, input int p);
        for (int off = 0; off < 8; off++)
            if (r[(p + off) % 8]) return (p + off) % 8;
        return -1;
    endfunction

    task automatic model_edge(input logic r, input logic [7:0] q);
        int w;
        bit released;
        if (r) begin
            m_owner = -1; m_idx = 0; m_ptr = 0; m_hold = 0; m_pre = 0;
            return;
        end
        m_pre = 0;
        if (m_owner < 0) begin
            w = first_from(q, m_ptr);
            if (w >= 0) begin
                m_owner = w; m_idx = w; m_hold = 1;
            end
        end else if (q[m_owner] && (MAXH == 0 || m_hold < MAXH)) begin
            m_hold = (m_hold < 255) ? m_hold + 1 : 255;
        end else begin
            released = !q[m_owner];
            m_ptr = (m_owner + 1) % 8;
            w = first_from(q, m_ptr);
            if (w < 0) begin
                m_owner = -1;
            end else begin
                m_pre = !released && (w != m_owner);
                m_owner = w; m_idx = w; m_hold = 1;
            end
        end
    endtask

    initial begin
        logic [7:0] q;
        logic [7:0] exp_g;
        logic       r;
        int         owner;

        bus.req = 8'h00;

        // reset, single request
        add(1, 8'h00, 8'h00, 3'd0, 0, 0);
        add(1, 8'h00, 8'h00, 3'd0, 0, 0);
        add(0, 8'h01, 8'h01, 3'd0, 1, 0);
        // preemption with two persistent requesters
        add(0, 8'h03, 8'h01, 3'd0, 1, 0);
        add(0, 8'h03, 8'h01, 3'd0, 1, 0);
        add(0, 8'h03, 8'h01, 3'd0, 1, 0);
        add(0, 8'h03, 8'h02, 3'd1, 1, 1);
        add(0, 8'h03, 8'h02, 3'd1, 1, 0);
        add(0, 8'h03, 8'h02, 3'd1, 1, 0);
        add(0, 8'h03, 8'h02, 3'd1, 1, 0);
        add(0, 8'h03, 8'h01, 3'd0, 1, 1);
        // sole requester passes the hold limit without preemption
        for (int i = 0; i < 10; i++) add(0, 8'h80, 8'h80, 3'd7, 1, 0);
        // owner 7 releases to idle, ptr wraps to 0
        add(0, 8'h00, 8'h00, 3'd7, 0, 0);
        add(0, 8'h81, 8'h01, 3'd0, 1, 0);
        // reset mid-grant
        add(0, 8'h10, 8'h10, 3'd4, 1, 0);
        add(1, 8'h10, 8'h00, 3'd0, 0, 0);
        add(0, 8'h30, 8'h10, 3'd4, 1, 0);

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].req);
            chk($sformatf("vec%0d grant", i), bus.grant, tbl[i].g);
            chk($sformatf("vec%0d grant_idx", i), {5'd0, bus.grant_idx}, {5'd0, tbl[i].idx});
            chk($sformatf("vec%0d grant_valid", i), {7'd0, bus.grant_valid}, {7'd0, tbl[i].v});
            chk($sformatf("vec%0d preempt", i), {7'd0, bus.preempt}, {7'd0, tbl[i].p});
        end

        // rotation: each owner drops its request for one cycle once granted
        step(1, 8'h00);
        step(0, 8'hFF);
        chk("rot start idx", {5'd0, bus.grant_idx}, 8'd0);
        owner = 0;
        for (int s = 1; s <= 8; s++) begin
            q = 8'hFF & ~(8'h01 << owner);
            step(0, q);
            chk($sformatf("rot%0d idx", s), {5'd0, bus.grant_idx}, 8'(s % 8));
            chk($sformatf("rot%0d valid", s), {7'd0, bus.grant_valid}, 8'd1);
            chk($sformatf("rot%0d preempt", s), {7'd0, bus.preempt}, 8'd0);
            owner = s % 8;
        end

        // randomized requests against the model
        step(1, 8'h00);
        model_edge(1'b1, 8'h00);
        q = 8'h00;
        for (int c = 0; c < 600; c++) begin
            case ($urandom_range(0, 3))
                0: q = 8'($urandom);
                1: q = q;
                2: if (m_owner >= 0) q = q & ~(8'h01 << m_owner);
                default: q = ($urandom_range(0, 2) == 0) ? 8'h00 : (8'h01 << $urandom_range(0, 7));
            endcase
            r = ($urandom_range(0, 63) == 0);
            step(r, q);
            model_edge(r, q);
            exp_g = (m_owner < 0) ? 8'h00 : (8'h01 << m_owner);
            chk($sformatf("rnd%0d grant", c), bus.grant, exp_g);
            chk($sformatf("rnd%0d grant_idx", c), {5'd0, bus.grant_idx}, 8'(m_idx));
            chk($sformatf("rnd%0d grant_valid", c), {7'd0, bus.grant_valid}, {7'd0, m_owner >= 0});
            chk($sformatf("rnd%0d preempt", c), {7'd0, bus.preempt}, {7'd0, m_pre});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_grant_arbiter8.md
Name: rr_grant_arbiter8

Overview:
- Sequential round-robin arbiter that shares one downstream resource (encoder/datapath slot) among 8 requesters.
- Produces a registered one-hot grant plus its 3-bit encoded index, matching the 8-to-3 encoding convention.
- Grants are held while the owner keeps requesting, up to a hold limit. A rotating pointer guarantees fairness.

Parameters:
- N, 8, number of requesters (fixed at 8 for this revision).
- IDXW, 3, width of encoded grant index.
- MAX_HOLD, 4, maximum consecutive grant cycles before forced preemption; 0 = unlimited.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- req  input  8  request vector; bit i = requester i.
- grant  output  8  registered one-hot grant, 0 when idle.
- grant_idx  output  3  encoded index of the granted requester; holds last value when idle.
- grant_valid  output  1  high when grant != 0.
- preempt  output  1  one-cycle pulse on the cycle a grant is changed by MAX_HOLD expiry.

Behaviour:
- Single clock; reset is synchronous and active-high.
- Reset (rst=1 at an edge): grant=0, grant_idx=0, grant_valid=0, preempt=0, ptr=0, hold_cnt=0, state=IDLE. Reset applies mid-grant: grant drops at that edge, with no completion.
- ptr (3 bits) is the highest-priority position. Winner = first i with req[i]=1 scanning ptr, ptr+1, ..., wrapping mod 8.
- States IDLE, BUSY. All outputs are registered; request-to-grant latency is 1 cycle.
- IDLE:
  - req=0: stay in IDLE.
  - req!=0: next edge sets grant=onehot(winner), grant_idx=winner, hold_cnt=1, go to BUSY.
- BUSY, owner k = grant_idx; each case below is evaluated at the edge:
  - req[k]=1 and (MAX_HOLD=0 or hold_cnt<MAX_HOLD): keep grant, hold_cnt+1 (saturating).
  - req[k]=0 (release): ptr=k+1 mod 8. If any other req is set, grant passes to the winner from the new ptr in the same edge, with no idle bubble, and hold_cnt=1. Otherwise grant=0 and go to IDLE.
  - req[k]=1 and hold_cnt==MAX_HOLD (expiry): ptr=k+1. If another requester exists, grant moves to it, preempt=1 for one cycle, hold_cnt=1. If k is the only requester, grant stays on k, hold_cnt=1, preempt=0.
- Requests not granted are not latched; a request dropped before being granted is lost.
- grant_idx always equals the encoded value of grant when grant_valid=1.
- Simultaneous release by owner and new requests: handled by the release rule. Newly raised bits are eligible in the same cycle.
- ptr wraps 7 -> 0. Requester 7 releasing sets ptr=0.
- hold_cnt is 8 bits and saturates. It is only compared when MAX_HOLD != 0.

Test Plan:
- Reset then single request:
  - rst=1 for 2 cycles; required: grant=0, grant_idx=0, grant_valid=0.
  - Then req=8'h01; required: grant=8'h01, grant_idx=0 exactly 1 cycle later.
- Round-robin rotation:
  - Hold req=8'hFF; each owner drops req for 1 cycle when granted, then re-raises.
  - Required grant_idx sequence: 0,1,2,3,4,5,6,7,0 with no idle cycles.
- Preemption (MAX_HOLD=4):
  - req=8'h03 held constant; required: grant=8'h01 for 4 cycles, then 8'h02 with preempt=1 for 1 cycle.
  - Then 8'h02 for 4 cycles, then 8'h01.
- Sole requester at limit:
  - req=8'h80 held 10 cycles; required: grant=8'h80 continuously, preempt never asserted.
- Wrap and release to idle:
  - Owner 7 releases with req=0; required: grant=0 next cycle, grant_valid=0.
  - Then req=8'h81; required: grant=8'h01, since ptr=0.
- Reset mid-grant:
  - Grant=8'h10 active, rst=1 for 1 cycle; required: grant=0 at that edge.
  - After rst=0 with req=8'h30; required: grant=8'h10, since ptr is reset to 0.
